// File: rtl/proc_pkg.sv
// Shared issuer types: opcodes, instruction-word layout, request entry and FSM states.
package proc_pkg;

  localparam int WORD_W = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int RX_MSB = 5;
  localparam int RX_LSB = 3;
  localparam int RY_MSB = 2;
  localparam int RY_LSB = 0;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_MOVI = 2'b01,
    OP_ADD  = 2'b10,
    OP_SUB  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_IR,
    ST_SEND_IMM,
    ST_WAIT_DONE
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [2:0]        rx;
    logic [2:0]        ry;
    logic [WORD_W-1:0] imm;
  } req_t;

  function automatic logic [WORD_W-1:0] encode_word(input req_t r);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = {1'b0, r.op};
    w[RX_MSB:RX_LSB] = r.rx;
    w[RY_MSB:RY_LSB] = r.ry;
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Request queue: head visible combinationally, push/pop take effect on the next edge.
// Backpressure: full blocks push (even with a same-cycle pop); pop on empty is ignored.
module instr_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_issuer.sv
// Feeds queued requests to the processor as DIN/Run words, one instruction in flight; req_ready = queue not full.
// Define ISSUER_TIMEOUT_EN to abort an instruction whose Done has not arrived after TIMEOUT_CYCLES.
module instr_issuer
  import proc_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  op_t               req_op,
  input  logic [2:0]        req_rx,
  input  logic [2:0]        req_ry,
  input  logic [WORD_W-1:0] req_imm,
  output logic [WORD_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic              busy,
  output logic              timeout
);

  req_t   push_entry;
  req_t   head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   expire;
  state_t state;
  state_t state_nxt;

  assign push_entry = '{op: req_op, rx: req_rx, ry: req_ry, imm: req_imm};
  assign req_ready  = !fifo_full;

  instr_fifo #(
    .WIDTH($bits(req_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clock),
    .rst      (Reset),
    .push     (req_valid),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

`ifdef ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             in_wait;
  logic             timeout_q;

  assign in_wait = (state == ST_SEND_IMM) || (state == ST_WAIT_DONE);
  assign expire  = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  // Done on the expiry cycle takes priority, so only a Done-less expiry is an abort.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wait_cnt <= in_wait ? wait_cnt + 1'b1 : '0;
      if (expire && !Done) timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign expire             = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // The head stays queued until Done, so WAIT_DONE re-derives the last driven word from it.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    Run       = 1'b0;
    DIN       = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) state_nxt = ST_SEND_IR;
      end
      ST_SEND_IR: begin
        Run       = 1'b1;
        DIN       = encode_word(head);
        state_nxt = (head.op == OP_MOVI) ? ST_SEND_IMM : ST_WAIT_DONE;
      end
      ST_SEND_IMM, ST_WAIT_DONE: begin
        if (state == ST_SEND_IMM || head.op == OP_MOVI) DIN = head.imm;
        else                                             DIN = encode_word(head);
        if (Done || expire) begin
          pop       = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_issuer.sv
// Bench for instr_issuer: vector table, hand-written corner sequences and a randomized run against a transaction model.
`timescale 1ns/1ps
module tb_instr_issuer;
  import proc_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 15;

  logic       Clock;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  op_t        req_op;
  logic [2:0] req_rx;
  logic [2:0] req_ry;
  logic [8:0] req_imm;
  logic [8:0] DIN;
  logic       Run;
  logic       Done;
  logic       busy;
  logic       timeout;

  instr_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clock(Clock), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rx(req_rx), .req_ry(req_ry), .req_imm(req_imm),
    .DIN(DIN), .Run(Run), .Done(Done), .busy(busy), .timeout(timeout)
  );

  int checks;
  int failures;
  int cyc;
  int last_run_cyc;
  int done_mode;   // 0: Done held low, 1: Done done_delay cycles after Run, 2: random
  int done_delay;
  bit model_on;

  typedef struct { int c; int w; } run_rec_t;
  run_rec_t run_log[$];

  typedef struct { int op; int rx; int ry; int imm; int delay; int word; int spacing; } vec_t;
  vec_t vt[7];

  typedef struct { int op; int rx; int ry; int imm; } mreq_t;
  mreq_t m_q[$];
  bit    m_issue;
  bit    m_inflight;
  bit    m_tmo;
  int    m_wait;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc++;
    end
  end

  initial begin
    last_run_cyc = -1000;
    forever begin
      @(negedge Clock);
      if (!Reset && Run) begin
        run_log.push_back('{cyc, int'(DIN)});
        last_run_cyc = cyc;
      end
    end
  end

  initial begin
    Done = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      case (done_mode)
        1:       Done = (cyc == last_run_cyc + done_delay);
        2:       Done = ($urandom_range(0, 2) == 0);
        default: Done = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  function automatic int word_of(input int op, input int rx, input int ry);
    return op * 64 + rx * 8 + ry;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int op, input int rx, input int ry, input int imm);
    req_valid = 1'b1;
    req_op    = op_t'(op[1:0]);
    req_rx    = rx[2:0];
    req_ry    = ry[2:0];
    req_imm   = imm[8:0];
    @(posedge Clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_run(input string name, output int c);
    c = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      if (Run) begin
        c = cyc;
        break;
      end
    end
    check(name, int'(c >= 0), 1);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      if (!busy) break;
    end
    check(name, int'(busy), 0);
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    @(posedge Clock);
    #1;
    Reset     = 1'b1;
    req_valid = 1'b0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  // Transaction-level reference: one instruction in flight, issued the cycle after the issuer is idle with work queued.
  task automatic model_step();
    int    exp_din;
    bit    exp_ready;
    bit    nxt_issue;
    bit    complete;
    mreq_t r;
    exp_ready = (m_q.size() < DEPTH);
    if (m_issue)         exp_din = word_of(m_q[0].op, m_q[0].rx, m_q[0].ry);
    else if (m_inflight) exp_din = (m_q[0].op == 1) ? m_q[0].imm : word_of(m_q[0].op, m_q[0].rx, m_q[0].ry);
    else                 exp_din = 0;
    check("rand_run", int'(Run), int'(m_issue));
    check("rand_busy", int'(busy), int'(m_issue || m_inflight));
    check("rand_ready", int'(req_ready), int'(exp_ready));
    check("rand_din", int'(DIN), exp_din);
    check("rand_timeout", int'(timeout), int'(m_tmo));
    nxt_issue = !m_issue && !m_inflight && (m_q.size() != 0);
    complete  = 1'b0;
    if (m_inflight) begin
      if (Done) complete = 1'b1;
`ifdef ISSUER_TIMEOUT_EN
      else if (m_wait == TMO - 1) begin
        complete = 1'b1;
        m_tmo    = 1'b1;
      end
`endif
      else m_wait++;
    end
    if (m_issue) begin
      m_inflight = 1'b1;
      m_wait     = 0;
    end
    if (complete) begin
      m_inflight = 1'b0;
      void'(m_q.pop_front());
    end
    if (req_valid && exp_ready) begin
      r.op  = int'(req_op);
      r.rx  = int'(req_rx);
      r.ry  = int'(req_ry);
      r.imm = int'(req_imm);
      m_q.push_back(r);
    end
    m_issue = nxt_issue;
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (model_on) model_step();
    end
  end

  initial begin
    int t1;
    int t2;
    int acc;
    bit taken;
    checks    = 0;
    failures  = 0;
    model_on  = 1'b0;
    done_mode = 0;
    done_delay = 1;
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = OP_MOV;
    req_rx    = '0;
    req_ry    = '0;
    req_imm   = '0;

    // {op, rx, ry, imm, Done delay after Run, expected word, expected Run-to-Run spacing}
    vt[0] = '{0, 7, 0, 9'h000, 1, 9'o070, 3};
    vt[1] = '{1, 2, 0, 9'h1A5, 1, 9'o120, 3};
    vt[2] = '{2, 1, 3, 9'h000, 3, 9'o213, 5};
    vt[3] = '{3, 4, 5, 9'h000, 3, 9'o345, 5};
    vt[4] = '{1, 5, 6, 9'h1FF, 2, 9'o156, 4};
    vt[5] = '{3, 7, 7, 9'h000, 4, 9'o377, 6};
    vt[6] = '{0, 0, 0, 9'h000, 1, 9'o000, 3};

    repeat (2) @(negedge Clock);
    check("reset_ready", int'(req_ready), 1);
    check("reset_run", int'(Run), 0);
    check("reset_din", int'(DIN), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_timeout", int'(timeout), 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;

    // Each vector is followed by MOV r1,r2 so the issue spacing can be measured.
    for (int i = 0; i < 7; i++) begin
      done_mode  = 1;
      done_delay = vt[i].delay;
      push(vt[i].op, vt[i].rx, vt[i].ry, vt[i].imm);
      push(0, 1, 2, 0);
      wait_run("vec_run_seen", t1);
      check("vec_word", int'(DIN), vt[i].word);
      check("vec_busy_at_run", int'(busy), 1);
      if (vt[i].op == 1) begin
        @(negedge Clock);
        check("vec_imm", int'(DIN), vt[i].imm);
        check("vec_run_one_cycle", int'(Run), 0);
      end
      wait_run("vec_next_run_seen", t2);
      check("vec_spacing", t2 - t1, vt[i].spacing);
      check("vec_next_word", int'(DIN), 9'o012);
      wait_idle("vec_idle");
      check("vec_idle_din", int'(DIN), 0);
    end

    // Fill a depth-4 queue with Done held low, then drain and check order.
    done_mode = 0;
    @(posedge Clock);
    #1;
    run_log.delete();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (acc < 5) begin
        req_valid = 1'b1;
        req_op    = OP_MOV;
        req_rx    = acc[2:0];
        req_ry    = acc[2:0];
      end else begin
        req_valid = 1'b0;
      end
      @(negedge Clock);
      taken = req_valid && req_ready;
      @(posedge Clock);
      #1;
      if (taken) acc++;
    end
    check("fill_accepted", acc, 4);
    check("fill_ready_low", int'(req_ready), 0);
    done_mode = 2;
    for (int i = 0; i < 60 && acc < 5; i++) begin
      @(negedge Clock);
      taken = req_valid && req_ready;
      @(posedge Clock);
      #1;
      if (taken) acc++;
    end
    req_valid = 1'b0;
    check("fill_fifth_accepted", acc, 5);
    for (int i = 0; i < 200; i++) begin
      @(negedge Clock);
      if (run_log.size() >= 5 && !busy) break;
    end
    check("fill_issue_count", run_log.size(), 5);
    for (int i = 0; i < 5 && i < run_log.size(); i++)
      check("fill_order", run_log[i].w, word_of(0, i, i));

    // Reset in WAIT_DONE with entries still queued.
    do_reset();
    done_mode = 0;
    run_log.delete();
    push(0, 3, 4, 0);
    push(2, 1, 1, 0);
    push(3, 2, 2, 0);
    repeat (2) @(negedge Clock);
    check("rst_mid_issued", run_log.size(), 1);
    check("rst_mid_din_held", int'(DIN), 9'o034);
    check("rst_mid_busy", int'(busy), 1);
    #2;
    Reset = 1'b1;
    #1;
    check("rst_async_run", int'(Run), 0);
    check("rst_async_din", int'(DIN), 0);
    check("rst_async_busy", int'(busy), 0);
    check("rst_async_ready", int'(req_ready), 1);
    @(posedge Clock);
    #1;
    Reset     = 1'b0;
    done_mode = 2;
    run_log.delete();
    repeat (12) @(negedge Clock);
    check("rst_no_reissue", run_log.size(), 0);
    check("rst_stays_idle", int'(busy), 0);
    @(posedge Clock);
    #1;
    done_mode  = 1;
    done_delay = 1;
    push(2, 6, 1, 0);
    wait_run("rst_new_run_seen", t1);
    check("rst_new_word", int'(DIN), 9'o261);
    wait_idle("rst_new_idle");

`ifdef ISSUER_TIMEOUT_EN
    do_reset();
    done_mode = 0;
    push(0, 1, 1, 0);
    push(0, 2, 2, 0);
    wait_run("tmo_run_seen", t1);
    repeat (15) @(negedge Clock);
    check("tmo_not_yet", int'(timeout), 0);
    check("tmo_still_busy", int'(busy), 1);
    @(negedge Clock);
    check("tmo_flag", int'(timeout), 1);
    check("tmo_idle", int'(busy), 0);
    wait_run("tmo_next_run_seen", t2);
    check("tmo_next_spacing", t2 - t1, 17);
    check("tmo_next_word", int'(DIN), 9'o022);
    wait_run("tmo_none_expected", t2);
    do_reset();
    check("tmo_cleared", int'(timeout), 0);
    done_mode  = 1;
    done_delay = 15;
    push(0, 1, 1, 0);
    push(0, 2, 2, 0);
    wait_run("tmo_race_run_seen", t1);
    wait_run("tmo_race_next_seen", t2);
    check("tmo_race_spacing", t2 - t1, 17);
    check("tmo_race_flag", int'(timeout), 0);
    wait_idle("tmo_race_idle");
    check("tmo_race_flag_end", int'(timeout), 0);
`endif

    // Randomized traffic against the transaction model.
    do_reset();
    m_q.delete();
    m_issue    = 1'b0;
    m_inflight = 1'b0;
    m_tmo      = 1'b0;
    m_wait     = 0;
    done_mode  = 2;
    model_on   = 1'b1;
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_op    = op_t'($urandom_range(0, 3));
      req_rx    = 3'($urandom_range(0, 7));
      req_ry    = 3'($urandom_range(0, 7));
      req_imm   = 9'($urandom_range(0, 511));
      @(posedge Clock);
      #1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge Clock);
      #1;
      if (m_q.size() == 0 && !m_inflight && !m_issue) break;
    end
    check("rand_drained", m_q.size(), 0);
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of request entries buffered (power of two, 2..16).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the cycles to wait for Done before abort (used only with REQ-024).
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all flops update on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: a request is offered.
REQ-006 The block SHALL have port req_ready, output, 1 bit: a request is accepted when req_valid and req_ready are both 1 at a rising edge.
REQ-007 The block SHALL have ports req_op (input, 2 bits, op_t), req_rx (input, 3 bits) and req_ry (input, 3 bits): opcode and register fields.
REQ-008 The block SHALL have port req_imm, input, 9 bits: immediate, used for MOVI only.
REQ-009 The block SHALL have ports DIN (output, 9 bits) and Run (output, 1 bit), connected to the processor data input and Run.
REQ-010 The block SHALL have port Done, input, 1 bit, driven by the processor's instruction-complete signal.
REQ-011 The block SHALL have ports busy (output, 1 bit: state is not IDLE) and timeout (output, 1 bit: sticky abort flag).

Function
REQ-012 Accepted requests SHALL be queued FIFO-ordered; req_ready = not full; there is no push when full, and a push and pop in the same cycle are both honoured.
REQ-013 The instruction word SHALL be encoded as DIN[8:6]={1'b0,op}, DIN[5:3]=rx, DIN[2:0]=ry, with MOV=00, MOVI=01, ADD=10, SUB=11.
REQ-014 The FSM SHALL have the states IDLE, SEND_IR, SEND_IMM and WAIT_DONE.
REQ-015 In IDLE with the FIFO non-empty, the FSM SHALL go to SEND_IR on the next edge; otherwise it stays in IDLE, with DIN=0 and Run=0.
REQ-016 In SEND_IR, DIN SHALL equal the encoded head entry and Run SHALL be 1 for exactly one cycle; the next state is SEND_IMM for MOVI and WAIT_DONE otherwise.
REQ-017 In SEND_IMM, DIN SHALL equal req_imm of the head entry and Run SHALL be 0; on Done=1 the head is popped and the next state is IDLE, otherwise WAIT_DONE.
REQ-018 In WAIT_DONE, DIN SHALL hold its last driven value and Run SHALL be 0; on Done=1 the head is popped and the next state is IDLE.
REQ-019 Done SHALL be ignored in IDLE and SEND_IR.
REQ-020 The minimum issue-to-issue spacing SHALL be: MOV 3 cycles, MOVI 3 cycles, ADD/SUB 5 cycles (Done in processor step T1/T1/T3).
REQ-021 The head entry SHALL remain in the FIFO until popped; new requests are accepted in every state.

Reset
REQ-022 Reset=1 SHALL, immediately and asynchronously, force state=IDLE, FIFO empty, DIN=0, Run=0, busy=0, timeout=0, req_ready=1 and the timeout counter to 0.
REQ-023 Reset asserted mid-instruction SHALL discard the in-flight entry and all queued entries, with no partial word re-issued after release.

Configuration
REQ-024 With ISSUER_TIMEOUT_EN defined, a counter SHALL run in SEND_IMM and WAIT_DONE, and reaching TIMEOUT_CYCLES without Done pops the head, sets timeout=1 (held until Reset) and returns to IDLE.
REQ-025 Without ISSUER_TIMEOUT_EN, the block SHALL have no counter, SHALL wait for Done indefinitely, and SHALL tie the timeout port to 0.
REQ-026 If Done arrives in the same cycle the counter expires, Done SHALL win: normal pop, timeout unchanged.

Structure
REQ-027 Package proc_pkg SHALL hold op_t, WORD_W=9, the opcode field positions, and the FSM state enum.
REQ-028 Sub-module instr_fifo SHALL implement the queue (parameterised width and depth, with full/empty flags); encoding and the FSM stay in instr_issuer.

Verification
REQ-029 Queue {MOVI, rx=2, imm=9'h1A5} with Done returned 1 cycle after Run -> DIN=9'o120 with Run=1 for one cycle, next cycle DIN=9'h1A5, then IDLE.
REQ-030 Queue ADD rx=1 ry=3 and SUB rx=4 ry=5 back-to-back with Done 3 cycles after Run -> Run pulses 5 cycles apart carrying 9'o213 then 9'o345.
REQ-031 Push 5 requests with FIFO_DEPTH=4 and Done held at 0 -> req_ready=0 after 4 accepted (or 5 if the head was popped), and no entry lost or reordered.
REQ-032 Assert Reset during WAIT_DONE with 3 entries queued -> Run=0, DIN=0, busy=0 at once, and no Run pulse after release until a new push.
REQ-033 With ISSUER_TIMEOUT_EN and Done never asserted for MOV -> timeout=1 after 15 WAIT_DONE cycles, and the next entry is issued; repeat with Done on cycle 15 -> timeout stays 0.
